intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- External interrupt controller directly upstream of the CP0 block.
- Synchronises and edge-detects up to N_SRC asynchronous interrupt lines, then latches pending sources and applies a software enable mask.
- Picks one source by fixed priority and drives CP0's single level input `ir_in`, along with a stable source id.
- Tracks the in-service interrupt through CP0's take/ERET cycle, so CP0 sees exactly one rising edge per delivered interrupt.

Parameters:
- N_SRC, 8, number of interrupt sources (1..32).
- SYNC_STAGES, 2, flip-flop stages in each source synchroniser (>=2).

Ports:
- clk  in  1  main clock.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- irq_src  in  N_SRC  asynchronous interrupt lines, active-high.
- cfg_we  in  1  config write strobe (from the CP0-store path).
- cfg_addr  in  2  config register select.
- cfg_wdata  in  32  config write data.
- cfg_rdata  out  32  config read data (combinational from cfg_addr).
- ir_taken  in  1  one-cycle pulse from CP0 when it accepts an interrupt (its `ir` output).
- eret  in  1  one-cycle pulse when ERET executes.
- ir_out  out  1  interrupt request level to CP0 `ir_in`.
- ir_id  out  5  id of the requested or in-service source.
- ir_active  out  1  high while an interrupt is in service.

Behaviour:
- Reset (rst_n=0 at posedge) clears all of the following: synchronisers, edge history, pending, enable, state=IDLE, ir_out=0, ir_id=0, ir_active=0. Reset mid-service abandons the interrupt silently.
- Source capture:
  - irq_src[i] passes through SYNC_STAGES flops.
  - A rising edge on the synchronised value sets pend[i] on the next cycle.
  - Latency from the irq_src edge to pend set is SYNC_STAGES+1 cycles. Levels held high do not re-trigger.
- Config registers (unused upper bits read 0, writes ignored):
  - addr 0 ENABLE: read/write, bits [N_SRC-1:0].
  - addr 1 PENDING: read; a write clears every bit where cfg_wdata=1 (write-1-to-clear).
  - addr 2 STATUS: read-only; bit 8 = ir_active, bits [4:0] = ir_id.
  - addr 3: reads 0; writes ignored.
- Selection: `cand = pend & enable`. The winner is the lowest set index.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: ir_out=0. If cand!=0, latch the winner into ir_id and go to REQ (ir_out=1 from the next cycle).
  - REQ: ir_out=1, ir_id held stable.
    - On ir_taken: clear pend[ir_id], go to SERVICE, ir_out=0, ir_active=1.
    - If cand becomes 0 before ir_taken (enable cleared or W1C): return to IDLE with ir_out=0.
  - SERVICE: ir_out=0, ir_active=1. On eret, go to IDLE with ir_active=0. The earliest next request is therefore one cycle after the IDLE entry, which guarantees CP0 sees a fresh rising edge.
  - eret in IDLE or REQ is ignored. ir_taken outside REQ is ignored.
- Simultaneous events:
  - A new edge on source i and a clear of pend[i] in the same cycle: set wins.
  - Priority among pending sources is only re-evaluated in IDLE. No preemption in REQ or SERVICE.
  - A cfg write and an ir_taken clear on different bits in the same cycle: both take effect.

Decomposition:
- Shared package/header holds:
  - cfg address constants: INTC_ENABLE=0, INTC_PENDING=1, INTC_STATUS=2.
  - FSM state encodings.
  - The STATUS bit positions.
- One natural sub-module: intr_sync_edge (a per-source synchroniser plus rising-edge detector), instantiated N_SRC times via generate.

Test Plan:
- Basic delivery:
  - Stimulus: write ENABLE=0x01, then pulse irq_src[0] for 1 cycle.
  - Response: pend=0x01 after 3 cycles and ir_out=1 with ir_id=0 on the following cycle.
  - Then pulse ir_taken: ir_out=0, ir_active=1, PENDING reads 0.
  - Then pulse eret: ir_active=0.
- Priority:
  - Stimulus: ENABLE=0xFF, raise src 5 and src 2 in the same cycle.
  - Response: ir_id=2 first. After its take/eret, ir_out rises again with ir_id=5.
- Masking:
  - Stimulus: ENABLE=0x00, pulse src 3.
  - Response: PENDING=0x08 and ir_out stays 0.
  - Then write ENABLE=0x08: ir_out=1, ir_id=3.
- Withdrawal: in REQ for src 4, write PENDING=0x10 (W1C) -> ir_out=0 next cycle, state IDLE, no ir_active.
- Edge behaviour and eret gating:
  - Stimulus: hold src 1 high for 20 cycles and pulse eret while IDLE.
  - Response: exactly one pend set, and eret has no effect.
  - Also: a new src 1 edge landing in the same cycle as the ir_taken clear leaves pend[1]=1.
- Reset mid-service: in SERVICE, assert rst_n=0 for 1 cycle -> all outputs 0, ENABLE and PENDING read 0.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg
// Shared definitions for the external interrupt controller:
//   - config register addresses
//   - FSM state encoding
//   - STATUS register bit positions
//   - fixed-priority (lowest index wins) selection helper
package intr_ctrl_pkg;

    localparam logic [1:0] INTC_ENABLE  = 2'd0;
    localparam logic [1:0] INTC_PENDING = 2'd1;
    localparam logic [1:0] INTC_STATUS  = 2'd2;

    localparam int STATUS_ACTIVE_BIT = 8;
    localparam int STATUS_ID_LSB     = 0;
    localparam int ID_W              = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_e;

    // Index of the lowest set bit; 0 when nothing is set (callers gate on cand != 0).
    function automatic logic [ID_W-1:0] lowest_set(input logic [31:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_ctrl_sync_edge.sv
// intr_sync_edge
// Per-source synchroniser followed by a rising-edge detector.
// Ports:
//   i_clk     main clock
//   i_rst_n   synchronous active-low reset
//   i_async   asynchronous interrupt line
//   o_rise    one-cycle pulse when the synchronised line goes 0 -> 1
module intr_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Combinational so that pend is set one cycle after the synchronised edge.
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl
// External interrupt controller feeding CP0's level input. Latches
// synchronised rising edges into a pending register, masks them with a
// software enable, picks the lowest-index candidate and tracks it through
// CP0's take / ERET handshake.
// Ports:
//   i_clk, i_rst_n               clock, synchronous active-low reset
//   i_irq_src[N_SRC]             asynchronous interrupt lines
//   i_cfg_we/addr/wdata          config write port
//   o_cfg_rdata                  config read data (combinational on addr)
//   i_ir_taken                   CP0 accepted the request
//   i_eret                       ERET executed
//   o_ir_out                     request level to CP0
//   o_ir_id                      requested / in-service source id
//   o_ir_active                  interrupt in service
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | nothing requested; arbitrate among candidates
// REQ      | o_ir_out high, o_ir_id frozen until CP0 takes it or it is withdrawn
// SERVICE  | CP0 is handling o_ir_id; wait for ERET
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] i_irq_src,
    input  logic             i_cfg_we,
    input  logic [1:0]       i_cfg_addr,
    input  logic [31:0]      i_cfg_wdata,
    output logic [31:0]      o_cfg_rdata,
    input  logic             i_ir_taken,
    input  logic             i_eret,
    output logic             o_ir_out,
    output logic [4:0]       o_ir_id,
    output logic             o_ir_active
);

    intc_state_e     r_state;
    intc_state_e     w_state_nxt;
    logic [ID_W-1:0] r_ir_id;
    logic [ID_W-1:0] w_id_nxt;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_enable;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_cand;
    logic [N_SRC-1:0] w_w1c_mask;
    logic [N_SRC-1:0] w_take_mask;
    logic [N_SRC-1:0] w_pend_nxt;
    logic [N_SRC-1:0] w_enable_nxt;
    logic             w_take;
    logic [31:0]      w_unused_wdata;

    assign w_unused_wdata = i_cfg_wdata;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        intr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_async (i_irq_src[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_cand = r_pend & r_enable;
    assign w_take = (r_state == ST_REQ) && i_ir_taken;

    always_comb begin
        w_take_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_take_mask[i] = w_take && (r_ir_id == ID_W'(i));
        end
    end

    assign w_w1c_mask   = (i_cfg_we && (i_cfg_addr == INTC_PENDING)) ? i_cfg_wdata[N_SRC-1:0] : '0;
    assign w_enable_nxt = (i_cfg_we && (i_cfg_addr == INTC_ENABLE))  ? i_cfg_wdata[N_SRC-1:0] : r_enable;
    // New edges are OR-ed in last so a set beats a simultaneous clear.
    assign w_pend_nxt   = (r_pend & ~w_w1c_mask & ~w_take_mask) | w_rise;

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_ir_id;
        case (r_state)
            ST_IDLE: begin
                if (w_cand != '0) begin
                    w_state_nxt = ST_REQ;
                    w_id_nxt    = lowest_set(32'(w_cand));
                end
            end
            ST_REQ: begin
                if (i_ir_taken) begin
                    w_state_nxt = ST_SERVICE;
                end else if ((w_pend_nxt & w_enable_nxt) == '0) begin
                    // Withdraw using next-cycle values so ir_out drops right after the write.
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (i_eret) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_ir_id  <= '0;
            r_pend   <= '0;
            r_enable <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ir_id  <= w_id_nxt;
            r_pend   <= w_pend_nxt;
            r_enable <= w_enable_nxt;
        end
    end

    assign o_ir_out    = (r_state == ST_REQ);
    assign o_ir_active = (r_state == ST_SERVICE);
    assign o_ir_id     = r_ir_id;

    always_comb begin
        o_cfg_rdata = '0;
        case (i_cfg_addr)
            INTC_ENABLE:  o_cfg_rdata[N_SRC-1:0] = r_enable;
            INTC_PENDING: o_cfg_rdata[N_SRC-1:0] = r_pend;
            INTC_STATUS: begin
                o_cfg_rdata[STATUS_ACTIVE_BIT]          = o_ir_active;
                o_cfg_rdata[STATUS_ID_LSB +: ID_W]      = r_ir_id;
            end
            default: o_cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    localparam int NS   = 8;
    localparam int SYNC = 2;

    typedef struct {
        logic        rst_n;
        logic [7:0]  irq;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        taken;
        logic        eret;
        logic        chk;
        logic        e_out;
        logic [4:0]  e_id;
        logic        e_act;
        logic [31:0] e_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_src;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        ir_taken;
    logic        eret;
    logic        ir_out;
    logic [4:0]  ir_id;
    logic        ir_active;

    int n_checks = 0;
    int n_err    = 0;
    int row      = 0;

    always #5 clk = ~clk;

    intr_ctrl #(.N_SRC(NS), .SYNC_STAGES(SYNC)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_irq_src   (irq_src),
        .i_cfg_we    (cfg_we),
        .i_cfg_addr  (cfg_addr),
        .i_cfg_wdata (cfg_wdata),
        .o_cfg_rdata (cfg_rdata),
        .i_ir_taken  (ir_taken),
        .i_eret      (eret),
        .o_ir_out    (ir_out),
        .o_ir_id     (ir_id),
        .o_ir_active (ir_active)
    );

    // Reference model: history of sampled lines, pending/enable sets and a
    // "requesting" / "in service" pair of flags.
    logic [7:0] m_samp [0:SYNC];
    logic [7:0] m_pend, m_en;
    logic       m_req, m_srv;
    logic [4:0] m_id;
    bit         m_valid = 0;

    function automatic int lowest(input logic [7:0] c);
        for (int i = 0; i < 8; i++) if (c[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] a);
        case (a)
            2'd0: return {24'd0, m_en};
            2'd1: return {24'd0, m_pend};
            2'd2: return (m_srv ? 32'h100 : 32'h0) | {27'd0, m_id};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input vec_t v);
        logic [7:0] rise, cand, np, ne, clr;
        if (!v.rst_n) begin
            for (int j = 0; j <= SYNC; j++) m_samp[j] = 8'h00;
            m_pend = 0; m_en = 0; m_req = 0; m_srv = 0; m_id = 0;
            m_valid = 1;
            return;
        end
        // A line sampled SYNC edges ago that was low one sample earlier is a new edge now.
        rise = m_samp[SYNC-1] & ~m_samp[SYNC];
        for (int j = SYNC; j > 0; j--) m_samp[j] = m_samp[j-1];
        m_samp[0] = v.irq;
        cand = m_pend & m_en;
        clr  = (v.we && v.addr == 2'd1) ? v.wdata[7:0] : 8'h00;
        if (m_req && v.taken) clr = clr | (8'h01 << m_id);
        np = (m_pend & ~clr) | rise;
        ne = (v.we && v.addr == 2'd0) ? v.wdata[7:0] : m_en;
        if (m_srv) begin
            if (v.eret) m_srv = 0;
        end else if (m_req) begin
            if (v.taken) begin m_req = 0; m_srv = 1; end
            else if ((np & ne) == 0) m_req = 0;
        end else if (cand != 0) begin
            m_req = 1;
            m_id  = 5'(lowest(cand));
        end
        m_pend = np;
        m_en   = ne;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d) got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        @(negedge clk);
        rst_n = v.rst_n; irq_src = v.irq; cfg_we = v.we; cfg_addr = v.addr;
        cfg_wdata = v.wdata; ir_taken = v.taken; eret = v.eret;
        #1;
        if (m_valid) begin
            chk("model ir_out",    32'(ir_out),    32'(m_req));
            chk("model ir_id",     32'(ir_id),     32'(m_id));
            chk("model ir_active", 32'(ir_active), 32'(m_srv));
            chk("model rdata",     cfg_rdata,      m_rdata(v.addr));
        end
        if (v.chk) begin
            chk("vec ir_out",    32'(ir_out),    32'(v.e_out));
            chk("vec ir_id",     32'(ir_id),     32'(v.e_id));
            chk("vec ir_active", 32'(ir_active), 32'(v.e_act));
            chk("vec rdata",     cfg_rdata,      v.e_rdata);
        end
        @(posedge clk);
        model_step(v);
        row++;
    endtask

    function automatic vec_t mk(logic r, logic [7:0] irq, logic we, logic [1:0] a, logic [31:0] wd,
                                logic tk, logic er, logic c, logic eo, logic [4:0] eid,
                                logic ea, logic [31:0] erd);
        vec_t v;
        v.rst_n = r; v.irq = irq; v.we = we; v.addr = a; v.wdata = wd;
        v.taken = tk; v.eret = er; v.chk = c; v.e_out = eo; v.e_id = eid;
        v.e_act = ea; v.e_rdata = erd;
        return v;
    endfunction

    task automatic cyc(logic [7:0] irq, logic we, logic [1:0] a, logic [31:0] wd, logic tk, logic er);
        run(mk(1, irq, we, a, wd, tk, er, 0, 0, 0, 0, 0));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 0, 2'd1, 0, 0, 0);
    endtask

    vec_t tbl[$];

    initial begin
        rst_n = 0; irq_src = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; ir_taken = 0; eret = 0;

        // rst irq we addr wdata tk er | chk out id act rdata
        tbl.push_back(mk(0, 8'h00, 0, 2'd0, 32'h00, 0, 0, 0, 0, 0, 0, 32'h000));
        tbl.push_back(mk(1, 8'h00, 0, 2'd0, 32'h00, 0, 0, 1, 0, 0, 0, 32'h000));
        tbl.push_back(mk(1, 8'h00, 1, 2'd0, 32'h01, 0, 0, 1, 0, 0, 0, 32'h000));
        tbl.push_back(mk(1, 8'h01, 0, 2'd0, 32'h00, 0, 0, 1, 0, 0, 0, 32'h001));
        tbl.push_back(mk(1, 8'h00, 0, 2'd1, 32'h00, 0, 0, 1, 0, 0, 0, 32'h000));
        tbl.push_back(mk(1, 8'h00, 0, 2'd1, 32'h00, 0, 0, 1, 0, 0, 0, 32'h000));
        tbl.push_back(mk(1, 8'h00, 0, 2'd1, 32'h00, 0, 0, 1, 0, 0, 0, 32'h001));
        tbl.push_back(mk(1, 8'h00, 0, 2'd2, 32'h00, 1, 0, 1, 1, 0, 0, 32'h000));
        tbl.push_back(mk(1, 8'h00, 0, 2'd1, 32'h00, 0, 0, 1, 0, 0, 1, 32'h000));
        tbl.push_back(mk(1, 8'h00, 0, 2'd2, 32'h00, 0, 1, 1, 0, 0, 1, 32'h100));
        tbl.push_back(mk(1, 8'h00, 0, 2'd2, 32'h00, 0, 0, 1, 0, 0, 0, 32'h000));
        tbl.push_back(mk(1, 8'h00, 1, 2'd0, 32'hFF, 0, 0, 1, 0, 0, 0, 32'h001));
        tbl.push_back(mk(1, 8'h24, 0, 2'd0, 32'h00, 0, 0, 1, 0, 0, 0, 32'h0FF));
        tbl.push_back(mk(1, 8'h00, 0, 2'd1, 32'h00, 0, 0, 1, 0, 0, 0, 32'h000));
        tbl.push_back(mk(1, 8'h00, 0, 2'd1, 32'h00, 0, 0, 1, 0, 0, 0, 32'h000));
        tbl.push_back(mk(1, 8'h00, 0, 2'd1, 32'h00, 0, 0, 1, 0, 0, 0, 32'h024));
        tbl.push_back(mk(1, 8'h00, 0, 2'd2, 32'h00, 1, 0, 1, 1, 2, 0, 32'h002));
        tbl.push_back(mk(1, 8'h00, 0, 2'd1, 32'h00, 0, 1, 1, 0, 2, 1, 32'h020));
        tbl.push_back(mk(1, 8'h00, 0, 2'd1, 32'h00, 0, 0, 1, 0, 2, 0, 32'h020));
        tbl.push_back(mk(1, 8'h00, 0, 2'd2, 32'h00, 1, 0, 1, 1, 5, 0, 32'h005));
        tbl.push_back(mk(1, 8'h00, 0, 2'd2, 32'h00, 0, 1, 1, 0, 5, 1, 32'h105));
        tbl.push_back(mk(1, 8'h00, 0, 2'd1, 32'h00, 0, 0, 1, 0, 5, 0, 32'h000));
        foreach (tbl[i]) run(tbl[i]);

        // Masking: pending latched while disabled, delivered once enabled.
        cyc(8'h00, 1, 2'd0, 32'h00, 0, 0);
        cyc(8'h08, 0, 2'd1, 0, 0, 0);
        idle(2);
        run(mk(1, 8'h00, 0, 2'd1, 0, 0, 0, 1, 0, 5, 0, 32'h08));
        run(mk(1, 8'h00, 1, 2'd0, 32'h08, 0, 0, 1, 0, 5, 0, 32'h00));
        idle(1);
        run(mk(1, 8'h00, 0, 2'd2, 0, 1, 0, 1, 1, 3, 0, 32'h003));
        cyc(8'h00, 0, 2'd1, 0, 0, 1);
        idle(1);

        // Withdrawal by W1C while requesting src 4.
        cyc(8'h00, 1, 2'd0, 32'h10, 0, 0);
        cyc(8'h10, 0, 2'd1, 0, 0, 0);
        idle(3);
        run(mk(1, 8'h00, 1, 2'd1, 32'h10, 0, 0, 1, 1, 4, 0, 32'h10));
        run(mk(1, 8'h00, 0, 2'd1, 0, 0, 0, 1, 0, 4, 0, 32'h00));
        run(mk(1, 8'h00, 0, 2'd2, 0, 0, 0, 1, 0, 4, 0, 32'h004));

        // Level held high: one pend set; eret in IDLE ignored.
        cyc(8'h00, 1, 2'd0, 32'h00, 0, 0);
        for (int i = 0; i < 20; i++) cyc(8'h02, 0, 2'd1, 0, 0, (i == 10));
        idle(3);
        run(mk(1, 8'h00, 1, 2'd1, 32'h02, 0, 0, 1, 0, 4, 0, 32'h02));
        run(mk(1, 8'h00, 0, 2'd1, 0, 0, 0, 1, 0, 4, 0, 32'h00));

        // New src 1 edge lands on the same edge as the take clear: pend[1] stays.
        cyc(8'h00, 1, 2'd0, 32'h02, 0, 0);
        cyc(8'h02, 0, 2'd1, 0, 0, 0);
        idle(3);
        run(mk(1, 8'h02, 0, 2'd2, 0, 0, 0, 1, 1, 1, 0, 32'h001));
        cyc(8'h02, 0, 2'd1, 0, 0, 0);
        cyc(8'h02, 0, 2'd1, 0, 1, 0);
        run(mk(1, 8'h00, 0, 2'd1, 0, 0, 1, 1, 0, 1, 1, 32'h02));
        idle(1);
        run(mk(1, 8'h00, 0, 2'd1, 0, 1, 0, 1, 1, 1, 0, 32'h02));

        // Reset while in service.
        run(mk(0, 8'h00, 0, 2'd2, 0, 0, 0, 1, 0, 1, 1, 32'h101));
        run(mk(1, 8'h00, 0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 32'h00));
        run(mk(1, 8'h00, 0, 2'd1, 0, 0, 0, 1, 0, 0, 0, 32'h00));

        // Randomized traffic against the model.
        begin
            logic [7:0] lines = 8'h00;
            for (int n = 0; n < 1500; n++) begin
                vec_t v;
                lines = lines ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
                v = mk(($urandom_range(0, 199) != 0), lines,
                       ($urandom_range(0, 99) < 15), 2'($urandom), $urandom,
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                       0, 0, 0, 0, 0);
                run(v);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
